// File: rtl/spi_ram.sv
// Single-port RAM behind the SPI slave. Decodes write-address, write-data, read-address
// and read-data commands. Define RAM_AUTO_INC_EN to auto-increment the pointers on data commands.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 addr_err
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(MEM_DEPTH);
`ifdef RAM_AUTO_INC_EN
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
`endif

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

  logic                 rx_valid_q, rx_valid_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_SIZE-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 addr_err_q, addr_err_d;

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload;
  logic                 accept;
  logic                 in_range;
  logic                 mem_we;

  assign cmd      = din[ADDR_SIZE+1:ADDR_SIZE];
  assign payload  = din[ADDR_SIZE-1:0];
  assign accept   = rx_valid && !rx_valid_q;
  assign in_range = {1'b0, payload} < DEPTH_W;

  always_comb begin
    rx_valid_d = rx_valid;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    if (accept) begin
      // Any accepted non-read command drops the held read response.
      tx_valid_d = (cmd == CMD_RD_DATA);
      case (cmd)
        CMD_WR_ADDR: begin
          if (in_range) wr_addr_d = payload;
          else          addr_err_d = 1'b1;
        end
        CMD_WR_DATA: begin
          mem_we = 1'b1;
`ifdef RAM_AUTO_INC_EN
          wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
`endif
        end
        CMD_RD_ADDR: begin
          if (in_range) rd_addr_d = payload;
          else          addr_err_d = 1'b1;
        end
        default: begin
          dout_d = mem[rd_addr_q];
`ifdef RAM_AUTO_INC_EN
          rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Contents survive reset; only the write strobe is gated.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[wr_addr_q] <= payload;
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram: a behavioural RAM model predicts each accepted command's
// response; a monitor pops and checks it the cycle after acceptance and checks holds otherwise.
module tb_spi_ram;

  localparam int DEPTH = 200;
  localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       addr_err;

  spi_ram #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tx;
    logic [7:0] dout;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model state
  int m_mem [DEPTH];
  int m_wr = 0, m_rd = 0, m_dout = 0;
  bit m_tx = 0;

  function automatic exp_t model(input logic [1:0] c, input int p);
    exp_t e;
    e.err = 1'b0;
    case (c)
      WA: if (p < DEPTH) m_wr = p; else e.err = 1'b1;
      WD: begin
        m_mem[m_wr] = p;
`ifdef RAM_AUTO_INC_EN
        m_wr = (m_wr + 1) % DEPTH;
`endif
      end
      RA: if (p < DEPTH) m_rd = p; else e.err = 1'b1;
      default: begin
        m_dout = m_mem[m_rd];
`ifdef RAM_AUTO_INC_EN
        m_rd = (m_rd + 1) % DEPTH;
`endif
      end
    endcase
    m_tx   = (c == RD);
    e.tx   = m_tx;
    e.dout = 8'(m_dout);
    return e;
  endfunction

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_dout = 0; m_tx = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input int p, input int hold, input int gap);
    sb.push_back(model(c, p));
    din      = {c, 8'(p)};
    rx_valid = 1'b1;
    repeat (hold) tick();
    rx_valid = 1'b0;
    din      = 10'($urandom);
    repeat (gap) tick();
  endtask

  // Monitor: tracks acceptance edges from the pins it sees, checks the DUT response.
  logic prev_rx = 1'b0;
  logic acc, rs;
  logic cur_tx = 1'b0;
  logic [7:0] cur_dout = 8'h00;
  exp_t me;

  initial begin
    forever begin
      @(posedge clk);
      rs      = rst_n;
      acc     = rs && rx_valid && !prev_rx;
      prev_rx = rs && rx_valid;
      @(negedge clk);
      if (!rs) begin
        chk("rst_dout", 32'(dout), 0);
        chk("rst_tx", 32'(tx_valid), 0);
        chk("rst_err", 32'(addr_err), 0);
        cur_tx = 1'b0;
      end else if (acc) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got accepted command want none queued at %0t", $time);
        end else begin
          me = sb.pop_front();
          chk("resp_tx", 32'(tx_valid), 32'(me.tx));
          if (me.tx) chk("resp_dout", 32'(dout), 32'(me.dout));
          chk("resp_err", 32'(addr_err), 32'(me.err));
          cur_tx   = me.tx;
          cur_dout = me.dout;
        end
      end else begin
        chk("idle_err", 32'(addr_err), 0);
        chk("hold_tx", 32'(tx_valid), 32'(cur_tx));
        if (cur_tx) chk("hold_dout", 32'(dout), 32'(cur_dout));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fill memory so every read has a known expectation
    for (int i = 0; i < DEPTH; i++) begin
      send(WA, i, 1, 1);
      send(WD, int'($urandom_range(0, 255)), 1, 1);
    end

    // Basic write/read path, then a non-read command drops tx_valid
    send(WA, 5, 3, 1);
    send(WD, 8'hA5, 3, 1);
    send(RA, 5, 3, 1);
    send(RD, 0, 3, 4);
    send(WA, 1, 3, 1);

    // Long hold: one command only
    send(WA, 7, 2, 1);
    send(WD, 8'h3C, 20, 1);
    send(WD, 8'h99, 2, 1);
    send(RA, 7, 1, 1);
    send(RD, 0, 1, 1);
    send(RA, 8, 1, 1);
    send(RD, 0, 1, 1);

    // Out-of-range address rejected; pointer kept
    send(WA, 12, 1, 1);
    send(WA, 8'hF0, 2, 1);
    send(WD, 8'h11, 2, 1);
    send(RA, 12, 1, 1);
    send(RA, 8'hFF, 1, 1);
    send(RD, 0, 1, 2);

    // Top-of-memory writes (wrap under auto-increment)
    send(WA, DEPTH - 1, 1, 1);
    send(WD, 8'h01, 1, 1);
    send(WD, 8'h02, 1, 1);
    send(RA, DEPTH - 1, 1, 1);
    send(RD, 0, 1, 1);
    send(RA, 0, 1, 1);
    send(RD, 0, 1, 1);
    send(RA, 1, 1, 1);
    send(RD, 0, 1, 1);

    // Back-to-back reads via 1-0-1 toggle
    send(WA, 3, 1, 1);
    send(WD, 8'h77, 1, 1);
    send(WA, 4, 1, 1);
    send(WD, 8'h44, 1, 1);
    send(RA, 3, 1, 1);
    send(RD, 0, 1, 1);
    send(RD, 0, 1, 3);

    // Reset while tx_valid=1 and rx_valid held high
    send(RA, 9, 1, 1);
    send(RD, 0, 1, 1);
    sb.push_back(model(RD, 0));
    din = {RD, 8'h00}; rx_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    sb.push_back(model(RD, 0));
    tick(); tick();
    rx_valid = 1'b0;
    tick();
    send(RA, 9, 1, 1);
    send(RD, 0, 1, 1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           int'($urandom_range(1, 4)), int'($urandom_range(1, 2)));
    end

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
